// File: rtl/matmul4_seq.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmul4_seq: sequences a 4x4 matrix product through one external         |
// | 4-element dot-product unit. Optional cycle counter: MATMUL4_SEQ_CYCCNT_EN |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module matmul4_seq #(
  parameter int DOT_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_we,
  input  logic        ld_sel,
  input  logic [3:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [31:0] dp_a0,
  output logic [31:0] dp_a1,
  output logic [31:0] dp_a2,
  output logic [31:0] dp_a3,
  output logic [31:0] dp_b0,
  output logic [31:0] dp_b1,
  output logic [31:0] dp_b2,
  output logic [31:0] dp_b3,
  input  logic [31:0] dp_ans,
  output logic [15:0] cyc_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [31:0] r_a [0:15];
  logic [31:0] r_b [0:15];
  logic [31:0] r_c [0:15];
  logic [31:0] r_dp_a [0:3];
  logic [31:0] r_dp_b [0:3];
  logic [31:0] w_a_fetch [0:3];
  logic [31:0] w_b_fetch [0:3];
  logic [1:0]  r_state;
  logic [3:0]  r_n;
  logic [3:0]  w_fetch_n;
  logic        w_idle;
  logic        w_issue;
  logic        w_start;
  logic        w_wr_a;
  logic        w_wr_b;
  logic        w_load_dp;
  logic        w_cap_v;
  logic [3:0]  w_cap_n;
  logic        w_pend;

  assign w_idle    = (r_state == S_IDLE);
  assign w_issue   = (r_state == S_ISSUE);
  assign w_start   = w_idle & start & ~rst;
  assign w_wr_a    = w_idle & ld_we & ~ld_sel & ~rst;
  assign w_wr_b    = w_idle & ld_we & ld_sel & ~rst;
  assign w_fetch_n = w_idle ? 4'd0 : (r_n + 4'd1);
  assign w_load_dp = w_start | (w_issue & (r_n != 4'd15));

  assign busy    = (r_state == S_ISSUE) | (r_state == S_DRAIN);
  assign done    = (r_state == S_DONE);
  assign rd_data = r_c[rd_addr];

  assign dp_a0 = r_dp_a[0];
  assign dp_a1 = r_dp_a[1];
  assign dp_a2 = r_dp_a[2];
  assign dp_a3 = r_dp_a[3];
  assign dp_b0 = r_dp_b[0];
  assign dp_b1 = r_dp_b[1];
  assign dp_b2 = r_dp_b[2];
  assign dp_b3 = r_dp_b[3];

  always_ff @(posedge clk) begin
    if (w_wr_a) r_a[ld_addr] <= ld_data;
    if (w_wr_b) r_b[ld_addr] <= ld_data;
  end

  // A load coinciding with start must reach the first issued operands.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_a_fetch[k] = r_a[{w_fetch_n[3:2], 2'(k)}];
      if (w_wr_a && ld_addr == {w_fetch_n[3:2], 2'(k)}) w_a_fetch[k] = ld_data;
      w_b_fetch[k] = r_b[{2'(k), w_fetch_n[1:0]}];
      if (w_wr_b && ld_addr == {2'(k), w_fetch_n[1:0]}) w_b_fetch[k] = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_n     <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        r_dp_a[k] <= 32'd0;
        r_dp_b[k] <= 32'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_ISSUE;
            r_n     <= 4'd0;
          end
        end
        S_ISSUE: begin
          r_n <= r_n + 4'd1;
          if (r_n == 4'd15) r_state <= (DOT_LAT == 0) ? S_DONE : S_DRAIN;
        end
        S_DRAIN: begin
          if (!w_pend) r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load_dp) begin
        for (int k = 0; k < 4; k++) begin
          r_dp_a[k] <= w_a_fetch[k];
          r_dp_b[k] <= w_b_fetch[k];
        end
      end
    end
  end

  generate
    if (DOT_LAT == 0) begin : g_lat0
      assign w_cap_v = w_issue;
      assign w_cap_n = r_n;
      assign w_pend  = 1'b0;
    end else begin : g_latn
      logic       r_tag_v [0:DOT_LAT-1];
      logic [3:0] r_tag_n [0:DOT_LAT-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < DOT_LAT; k++) begin
            r_tag_v[k] <= 1'b0;
            r_tag_n[k] <= 4'd0;
          end
        end else begin
          r_tag_v[0] <= w_issue;
          r_tag_n[0] <= r_n;
          for (int k = 1; k < DOT_LAT; k++) begin
            r_tag_v[k] <= r_tag_v[k-1];
            r_tag_n[k] <= r_tag_n[k-1];
          end
        end
      end

      // The last stage is captured on the same edge that leaves DRAIN.
      always_comb begin
        w_pend = 1'b0;
        for (int k = 0; k < DOT_LAT - 1; k++) w_pend = w_pend | r_tag_v[k];
      end

      assign w_cap_v = r_tag_v[DOT_LAT-1];
      assign w_cap_n = r_tag_n[DOT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst && w_cap_v) r_c[w_cap_n] <= dp_ans;
  end

`ifdef MATMUL4_SEQ_CYCCNT_EN
  logic [15:0] r_cnt;
  logic [15:0] r_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
      r_cyc <= 16'd0;
    end else begin
      if (w_start) r_cnt <= 16'd0;
      else if (busy && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      if (done) r_cyc <= r_cnt;
    end
  end

  assign cyc_cnt = r_cyc;
`else
  assign cyc_cnt = 16'd0;
`endif

endmodule
`default_nettype wire
